// File: rtl/nec_stack_sequencer.sv
// Multi-register stack transfer engine: walks a slot bitmask and issues one stack
// bus word per set slot, pre-decrementing SP on push and post-incrementing on pop.
module nec_stack_sequencer #(
    parameter int unsigned       SLOTS        = 16,
    parameter int unsigned       DATA_W       = 16,
    parameter int unsigned       SP_STEP      = 2,
    parameter logic [SLOTS-1:0]  DISCARD_MASK = 16'h0010
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       dir,
    input  logic [SLOTS-1:0]           mask,
    input  logic [15:0]                sp_in,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(SLOTS)-1:0]   slot,
    input  logic [DATA_W-1:0]          reg_rd_data,
    output logic                       reg_wr,
    output logic [DATA_W-1:0]          reg_wr_data,
    output logic                       bus_req,
    output logic                       bus_we,
    output logic [15:0]                bus_addr,
    output logic [DATA_W-1:0]          bus_wdata,
    input  logic                       bus_ack,
    input  logic [DATA_W-1:0]          bus_rdata,
    output logic [15:0]                sp_out,
    output logic                       sp_wr
);

    localparam int unsigned SW   = $clog2(SLOTS);
    localparam logic [15:0] STEP = 16'(SP_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [SLOTS-1:0] pending_q, pending_d;
    logic [15:0]      sp_q, sp_d;

    logic [SW-1:0]    slot_enc;
    logic [SLOTS-1:0] slot_oh;
    logic [SLOTS-1:0] pending_left;
    logic             found;
    logic             ack_cycle;

    // Push walks lowest-first, pop highest-first, so pop undoes a matching push.
    always_comb begin
        slot_enc = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (pending_q[i]) begin
                if (dir_q) begin
                    slot_enc = SW'(i);
                end else if (!found) begin
                    slot_enc = SW'(i);
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        slot_oh           = '0;
        slot_oh[slot_enc] = 1'b1;
    end

    assign pending_left = pending_q & ~slot_oh;
    assign ack_cycle    = (state_q == BUS) && bus_ack;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        pending_d = pending_q;
        sp_d      = sp_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d     = dir;
                    pending_d = mask;
                    if (mask != '0) begin
                        state_d = BUS;
                        sp_d    = dir ? sp_in : (sp_in - STEP);
                    end else begin
                        state_d = DONE;
                        sp_d    = sp_in;
                    end
                end
            end
            BUS: begin
                if (bus_ack) begin
                    pending_d = pending_left;
                    // Push stops decrementing on the last slot so SP ends at the last written word.
                    if (dir_q) begin
                        sp_d = sp_q + STEP;
                    end else if (pending_left != '0) begin
                        sp_d = sp_q - STEP;
                    end
                    if (pending_left == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            pending_q <= '0;
            sp_q      <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            sp_q      <= sp_d;
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        sp_wr       = (state_q == DONE);
        slot        = slot_enc;
        bus_req     = (state_q == BUS);
        bus_we      = (state_q == BUS) && !dir_q;
        bus_addr    = sp_q;
        bus_wdata   = reg_rd_data;
        sp_out      = sp_q;
        reg_wr      = ack_cycle && dir_q && !DISCARD_MASK[slot_enc];
        reg_wr_data = reg_wr ? bus_rdata : '0;
    end

endmodule

// File: tb/tb_nec_stack_sequencer.sv
// Directed bench for nec_stack_sequencer: push/pop ordering, discard slot, wait
// states, SP wrap, empty mask, ignored start and asynchronous reset mid-transfer.
module tb_nec_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        dir;
    logic [15:0] mask;
    logic [15:0] sp_in;
    logic        busy;
    logic        done;
    logic [3:0]  slot;
    logic [15:0] reg_rd_data;
    logic        reg_wr;
    logic [15:0] reg_wr_data;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack;
    logic [15:0] bus_rdata;
    logic [15:0] sp_out;
    logic        sp_wr;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    // Register file and memory models: data derived from slot / address.
    assign reg_rd_data = 16'hA000 | {12'h000, slot};
    assign bus_rdata   = {8'hC3, bus_addr[7:0]};

    nec_stack_sequencer #(
        .SLOTS(16),
        .DATA_W(16),
        .SP_STEP(2),
        .DISCARD_MASK(16'h0010)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .dir(dir),
        .mask(mask),
        .sp_in(sp_in),
        .busy(busy),
        .done(done),
        .slot(slot),
        .reg_rd_data(reg_rd_data),
        .reg_wr(reg_wr),
        .reg_wr_data(reg_wr_data),
        .bus_req(bus_req),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack(bus_ack),
        .bus_rdata(bus_rdata),
        .sp_out(sp_out),
        .sp_wr(sp_wr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int unsigned writes;
        int unsigned wr_count;
        logic        seen_done;
        logic [15:0] exp_addr;
        logic [3:0]  exp_slot;

        reset_n = 1'b0;
        start   = 1'b0;
        dir     = 1'b0;
        mask    = 16'h0000;
        sp_in   = 16'h0000;
        bus_ack = 1'b0;
        #2;
        chk("rst_busy",    32'(busy),        32'h0);
        chk("rst_done",    32'(done),        32'h0);
        chk("rst_slot",    32'(slot),        32'h0);
        chk("rst_reg_wr",  32'(reg_wr),      32'h0);
        chk("rst_wr_data", 32'(reg_wr_data), 32'h0);
        chk("rst_req",     32'(bus_req),     32'h0);
        chk("rst_we",      32'(bus_we),      32'h0);
        chk("rst_addr",    32'(bus_addr),    32'h0);
        chk("rst_sp_out",  32'(sp_out),      32'h0);
        chk("rst_sp_wr",   32'(sp_wr),       32'h0);
        cyc();
        reset_n = 1'b1;
        cyc();

        // Push 0x00FF from 0x1000, zero-wait.
        start = 1'b1; dir = 1'b0; mask = 16'h00FF; sp_in = 16'h1000; bus_ack = 1'b1;
        #1;
        chk("push_idle_busy", 32'(busy), 32'h0);
        cyc();
        start = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_addr = 16'h1000 - 16'(2 * (i + 1));
            exp_slot = 4'(i);
            chk("push_busy",  32'(busy),      32'h1);
            chk("push_req",   32'(bus_req),   32'h1);
            chk("push_we",    32'(bus_we),    32'h1);
            chk("push_slot",  32'(slot),      32'(exp_slot));
            chk("push_addr",  32'(bus_addr),  32'(exp_addr));
            chk("push_wdata", 32'(bus_wdata), 32'(16'hA000 | {12'h000, exp_slot}));
            chk("push_regwr", 32'(reg_wr),    32'h0);
            chk("push_done0", 32'(done),      32'h0);
            cyc();
        end
        chk("push_done",   32'(done),    32'h1);
        chk("push_sp_wr",  32'(sp_wr),   32'h1);
        chk("push_sp_out", 32'(sp_out),  32'h0FF0);
        chk("push_noreq",  32'(bus_req), 32'h0);
        cyc();
        chk("push_idle",   32'(busy),    32'h0);
        chk("push_pulse",  32'(done),    32'h0);

        // Pop R 0x00FF from 0x0FF0; slot 4 is a discard slot.
        start = 1'b1; dir = 1'b1; mask = 16'h00FF; sp_in = 16'h0FF0; bus_ack = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        wr_count = 0;
        for (int i = 0; i < 8; i++) begin
            exp_addr = 16'h0FF0 + 16'(2 * i);
            exp_slot = 4'(7 - i);
            chk("pop_req",   32'(bus_req),  32'h1);
            chk("pop_we",    32'(bus_we),   32'h0);
            chk("pop_slot",  32'(slot),     32'(exp_slot));
            chk("pop_addr",  32'(bus_addr), 32'(exp_addr));
            chk("pop_regwr", 32'(reg_wr),   (exp_slot == 4'd4) ? 32'h0 : 32'h1);
            chk("pop_wdata", 32'(reg_wr_data),
                (exp_slot == 4'd4) ? 32'h0 : 32'({8'hC3, exp_addr[7:0]}));
            if (reg_wr) wr_count++;
            cyc();
        end
        chk("pop_wr_count", wr_count,     32'd7);
        chk("pop_done",     32'(done),   32'h1);
        chk("pop_sp_out",   32'(sp_out), 32'h1000);
        cyc();

        // Single-slot push with two wait cycles.
        start = 1'b1; dir = 1'b0; mask = 16'h0002; sp_in = 16'h2000; bus_ack = 1'b0;
        cyc();
        start = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus_ack = 1'b1;
            #1;
            chk("wait_req",  32'(bus_req),  32'h1);
            chk("wait_addr", 32'(bus_addr), 32'h1FFE);
            chk("wait_slot", 32'(slot),     32'h1);
            chk("wait_done", 32'(done),     32'h0);
            cyc();
        end
        bus_ack = 1'b0;
        #1;
        chk("wait_done_pulse", 32'(done),   32'h1);
        chk("wait_sp_out",     32'(sp_out), 32'h1FFE);
        cyc();

        // SP wrap on push and on pop.
        start = 1'b1; dir = 1'b0; mask = 16'h0001; sp_in = 16'h0000; bus_ack = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        chk("wrap_push_addr", 32'(bus_addr), 32'hFFFE);
        cyc();
        chk("wrap_push_sp",   32'(sp_out),   32'hFFFE);
        cyc();
        start = 1'b1; dir = 1'b1; mask = 16'h0001; sp_in = 16'hFFFE;
        cyc();
        start = 1'b0;
        #1;
        chk("wrap_pop_addr",  32'(bus_addr),    32'hFFFE);
        chk("wrap_pop_wr",    32'(reg_wr),      32'h1);
        chk("wrap_pop_data",  32'(reg_wr_data), 32'hC3FE);
        cyc();
        chk("wrap_pop_done",  32'(done),        32'h1);
        chk("wrap_pop_sp",    32'(sp_out),      32'h0000);
        cyc();

        // Empty mask.
        start = 1'b1; dir = 1'b0; mask = 16'h0000; sp_in = 16'h1234;
        cyc();
        start = 1'b0;
        #1;
        chk("empty_done",  32'(done),    32'h1);
        chk("empty_busy",  32'(busy),    32'h1);
        chk("empty_noreq", 32'(bus_req), 32'h0);
        chk("empty_sp",    32'(sp_out),  32'h1234);
        cyc();
        chk("empty_idle",  32'(busy),    32'h0);

        // start held high while busy must be ignored.
        start = 1'b1; dir = 1'b0; mask = 16'h000F; sp_in = 16'h3000; bus_ack = 1'b1;
        cyc();
        dir = 1'b1; mask = 16'hFFFF; sp_in = 16'h0000;
        #1;
        writes    = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 20 && !seen_done; i++) begin
            if (bus_req && bus_we && bus_ack) writes++;
            if (done) begin
                seen_done = 1'b1;
                start     = 1'b0;
                chk("ign_sp_out", 32'(sp_out), 32'h2FF8);
            end else begin
                cyc();
            end
        end
        chk("ign_seen_done", 32'(seen_done), 32'h1);
        chk("ign_writes",    writes,         32'd4);
        cyc();
        chk("ign_idle",      32'(busy),      32'h0);

        // Asynchronous reset during the third slot of a push.
        start = 1'b1; dir = 1'b0; mask = 16'h00FF; sp_in = 16'h1000; bus_ack = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        #1;
        chk("mid_slot_pre", 32'(slot), 32'h2);
        reset_n = 1'b0;
        #1;
        chk("mid_busy",    32'(busy),        32'h0);
        chk("mid_done",    32'(done),        32'h0);
        chk("mid_slot",    32'(slot),        32'h0);
        chk("mid_reg_wr",  32'(reg_wr),      32'h0);
        chk("mid_wr_data", 32'(reg_wr_data), 32'h0);
        chk("mid_req",     32'(bus_req),     32'h0);
        chk("mid_we",      32'(bus_we),      32'h0);
        chk("mid_addr",    32'(bus_addr),    32'h0);
        chk("mid_sp_out",  32'(sp_out),      32'h0);
        chk("mid_sp_wr",   32'(sp_wr),       32'h0);
        chk("mid_wdata",   32'(bus_wdata),   32'hA000);
        cyc();
        reset_n = 1'b1;
        cyc();
        start = 1'b1; dir = 1'b0; mask = 16'h0003; sp_in = 16'h4000; bus_ack = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        chk("post_slot0", 32'(slot),     32'h0);
        chk("post_addr0", 32'(bus_addr), 32'h3FFE);
        cyc();
        chk("post_slot1", 32'(slot),     32'h1);
        chk("post_addr1", 32'(bus_addr), 32'h3FFC);
        cyc();
        chk("post_done",  32'(done),     32'h1);
        chk("post_sp",    32'(sp_out),   32'h3FFC);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
